// File: rtl/pram_loader.sv
// Write side of the 32x64 program RAM: packs pairs of host words into instructions.
// Optional XOR checksum of written instructions when PRAM_LOADER_CHECKSUM_EN is defined.
module pram_loader #(
    parameter int IN_W   = 32,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [5:0]        num_instr,
    input  logic              s_valid,
    input  logic [IN_W-1:0]   s_data,
    output logic              s_ready,
    output logic              pram_wea,
    output logic [ADDR_W-1:0] pram_waddr,
    output logic [DATA_W-1:0] pram_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic [5:0]        instr_cnt,
    output logic [DATA_W-1:0] chk_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WR,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [5:0]        num_q, num_d;
    logic [IN_W-1:0]   lo_q, lo_d;
    logic [5:0]        cnt_d;
    logic              ready_d, busy_d, done_d, err_d, wea_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [DATA_W-1:0] wdata_d;

    logic              hs;
    logic              range_bad;
    logic              accept;
    logic [ADDR_W:0]   range_sum;

    assign hs        = s_valid && s_ready;
    // Range check is one bit wider than the address so base+num cannot wrap.
    assign range_sum = {1'b0, base_addr} + (ADDR_W+1)'(num_instr);
    assign range_bad = range_sum > (ADDR_W+1)'(DEPTH);
    assign accept    = (state_q == S_IDLE) && start && !range_bad;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (num_instr == '0) ? S_DONE : S_LO;
                end
            end
            S_LO:   if (hs) state_d = S_HI;
            S_HI:   if (hs) state_d = S_WR;
            // instr_cnt already holds the post-write count while in WR.
            S_WR:   state_d = (instr_cnt == num_q) ? S_DONE : S_LO;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d = (state_d == S_LO) || (state_d == S_HI);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_DONE);
        err_d   = (state_q == S_IDLE) && start && range_bad;
        wea_d   = (state_q == S_HI) && hs;
        waddr_d = pram_waddr;
        wdata_d = pram_wdata;
        cnt_d   = instr_cnt;
        base_d  = base_q;
        num_d   = num_q;
        lo_d    = lo_q;
        if (accept && (num_instr != '0)) begin
            base_d = base_addr;
            num_d  = num_instr;
            cnt_d  = '0;
        end
        if ((state_q == S_LO) && hs) begin
            lo_d = s_data;
        end
        if (wea_d) begin
            waddr_d = base_q + ADDR_W'(instr_cnt);
            wdata_d = {s_data, lo_q};
            cnt_d   = instr_cnt + 6'd1;
        end
    end

`ifdef PRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (accept && (num_instr != '0)) begin
            chk_d = '0;
        end else if (wea_d) begin
            chk_d = chk_q ^ wdata_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk_out = chk_q;
`else
    assign chk_out = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_range  <= 1'b0;
            pram_wea   <= 1'b0;
            pram_waddr <= '0;
            pram_wdata <= '0;
            instr_cnt  <= '0;
            base_q     <= '0;
            num_q      <= '0;
            lo_q       <= '0;
        end else begin
            s_ready    <= ready_d;
            busy       <= busy_d;
            done       <= done_d;
            err_range  <= err_d;
            pram_wea   <= wea_d;
            pram_waddr <= waddr_d;
            pram_wdata <= wdata_d;
            instr_cnt  <= cnt_d;
            base_q     <= base_d;
            num_q      <= num_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_pram_loader.sv
// Directed/randomized bench for pram_loader; expected writes come from a queue model.
module tb_pram_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [5:0]  num_instr = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        pram_wea;
    logic [10:0] pram_waddr;
    logic [63:0] pram_wdata;
    logic        busy;
    logic        done;
    logic        err_range;
    logic [5:0]  instr_cnt;
    logic [63:0] chk_out;

    pram_loader #(
        .IN_W  (32),
        .DATA_W(64),
        .ADDR_W(11),
        .DEPTH (32)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .num_instr (num_instr),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .pram_wea  (pram_wea),
        .pram_waddr(pram_waddr),
        .pram_wdata(pram_wdata),
        .busy      (busy),
        .done      (done),
        .err_range (err_range),
        .instr_cnt (instr_cnt),
        .chk_out   (chk_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    logic [63:0] exp_chk = '0;
    int          tests = 0;
    int          fails = 0;
    int          wea_dbl = 0;
    int          err_pulses = 0;
    int          ready_hi = 0;
    logic        prev_wea = 1'b0;

    // Observer: records every PRAM write and notes strobes wider than one cycle.
    always @(negedge clk) begin
        if (pram_wea) obs_q.push_back('{pram_waddr, pram_wdata});
        if (pram_wea && prev_wea) wea_dbl++;
        prev_wea = pram_wea;
        if (err_range) err_pulses++;
        if (s_ready) ready_hi++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int b, input int n);
        base_addr = 11'(b);
        num_instr = 6'(n);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        int n;
        repeat ($urandom_range(gap_max, 0)) begin
            s_valid = 1'b0;
            s_data = $urandom;
            cyc();
        end
        s_valid = 1'b1;
        s_data = w;
        n = 0;
        while (!s_ready && n < 100) begin
            cyc();
            n++;
        end
        check("hs_timeout", 64'(n >= 100), 64'd0);
        cyc();
        s_valid = 1'b0;
        s_data = $urandom;
    endtask

    task automatic expect_wr(input int a, input logic [63:0] d);
        exp_q.push_back('{11'(a), d});
        exp_chk ^= d;
    endtask

    task automatic load_instr(input int b, input int idx, input int gap_max);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = $urandom;
        hi = $urandom;
        expect_wr(b + idx, {hi, lo});
        send_word(lo, gap_max);
        send_word(hi, gap_max);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
        cyc();
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check({tag, "_addr"}, 64'(obs_q[i].a), 64'(exp_q[i].a));
                check({tag, "_data"}, obs_q[i].d, exp_q[i].d);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_chk(input string tag);
`ifdef PRAM_LOADER_CHECKSUM_EN
        check(tag, chk_out, exp_chk);
`else
        check(tag, chk_out, 64'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) cyc();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_wea", 64'(pram_wea), 64'd0);
        check("rst_waddr", 64'(pram_waddr), 64'd0);
        check("rst_wdata", pram_wdata, 64'd0);
        check("rst_cnt", 64'(instr_cnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_range), 64'd0);
        check("rst_chk", chk_out, 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Directed two-instruction load
        exp_chk = '0;
        pulse_start(0, 2);
        expect_wr(0, 64'h22222222_11111111);
        expect_wr(1, 64'h44444444_33333333);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        @(negedge clk);
        check("t1_wea_latency", 64'(pram_wea), 64'd1);
        send_word(32'h33333333, 0);
        send_word(32'h44444444, 0);
        wait_done("t1_done");
        check_writes("t1");
        check("t1_cnt", 64'(instr_cnt), 64'd2);
        check_chk("t1_chk");

        // Range rejections
        err_pulses = 0;
        pulse_start(30, 3);
        @(negedge clk);
        check("t2_err", 64'(err_range), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);
        cyc();
        @(negedge clk);
        check("t2_err_clear", 64'(err_range), 64'd0);
        pulse_start(1, 32);
        pulse_start(0, 33);
        repeat (3) cyc();
        check("t2_err_pulses", 64'(err_pulses), 64'd3);
        check("t2_no_write", 64'(obs_q.size()), 64'd0);

        // Zero-length load
        ready_hi = 0;
        pulse_start(0, 0);
        @(negedge clk);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_done_early", 64'(done), 64'd0);
        cyc();
        @(negedge clk);
        check("t3_done", 64'(done), 64'd1);
        check("t3_busy_after", 64'(busy), 64'd0);
        cyc();
        check("t3_ready", 64'(ready_hi), 64'd0);
        check("t3_no_write", 64'(obs_q.size()), 64'd0);

        // Full-depth load with random stalls
        exp_chk = '0;
        wea_dbl = 0;
        pulse_start(0, 32);
        @(negedge clk);
        check("t4_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 32; i++) load_instr(0, i, 3);
        wait_done("t4_done");
        check_writes("t4");
        check("t4_cnt", 64'(instr_cnt), 64'd32);
        check("t4_wea_width", 64'(wea_dbl), 64'd0);
        check_chk("t4_chk");

        // Top address
        exp_chk = '0;
        pulse_start(31, 1);
        load_instr(31, 0, 2);
        wait_done("t4b_done");
        check_writes("t4b");
        check("t4b_cnt", 64'(instr_cnt), 64'd1);
        check_chk("t4b_chk");

        // Reset mid-load, then restart
        pulse_start(0, 4);
        load_instr(0, 0, 1);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_wea", 64'(pram_wea), 64'd0);
        check("t5_waddr", 64'(pram_waddr), 64'd0);
        check("t5_wdata", pram_wdata, 64'd0);
        check("t5_cnt", 64'(instr_cnt), 64'd0);
        check("t5_chk", chk_out, 64'd0);
        check("t5_ready", 64'(s_ready), 64'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        check_writes("t5_pre");
        exp_chk = '0;
        pulse_start(8, 1);
        load_instr(8, 0, 2);
        wait_done("t5_done");
        check_writes("t5");
        check("t5_cnt_final", 64'(instr_cnt), 64'd1);
        check_chk("t5_chk_final");

        // start while busy is ignored
        exp_chk = '0;
        err_pulses = 0;
        pulse_start(4, 2);
        load_instr(4, 0, 1);
        pulse_start(20, 5);
        @(negedge clk);
        check("t6_busy", 64'(busy), 64'd1);
        load_instr(4, 1, 1);
        wait_done("t6_done");
        check_writes("t6");
        check("t6_cnt", 64'(instr_cnt), 64'd2);
        check("t6_err", 64'(err_pulses), 64'd0);
        check_chk("t6_chk");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
